// File: rtl/comparator_pkg.sv
// Shared types and constants for the comparator and its bubble-sort sequencer.
package comparator_pkg;

    localparam int unsigned DATA_W = 4;

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DRAIN
    } sort_state_t;

    // Index width for a DEPTH-entry buffer; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth <= 32'd2) ? 32'd1 : 32'($clog2(depth));
    endfunction

endpackage

// File: rtl/comparator_sort_ctrl_if.sv
// Valid/ready streaming ports of the sorter: operand load in, sorted entries out.
interface comparator_sort_ctrl_if;
    import comparator_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/comparator.sv
// Combinational magnitude comparator; exactly one of EQ, A_GT_B, B_GT_A is high.
module comparator
    import comparator_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              EQ,
    output logic              A_GT_B,
    output logic              B_GT_A
);

    assign EQ     = (A == B);
    assign A_GT_B = (A > B);
    assign B_GT_A = (B > A);

endmodule

// File: rtl/comparator_sort_ctrl.sv
// Bubble-sort sequencer: loads DEPTH values, sorts them in place with one shared comparator
// (one compare per clock), then streams them out in ascending order.
module comparator_sort_ctrl
    import comparator_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    comparator_sort_ctrl_if.slave bus,
    output logic                  sorted,
    output logic                  busy
);

    localparam int unsigned     IdxW    = idx_width(DEPTH);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);
    localparam logic [IdxW-1:0] LastJ   = IdxW'(DEPTH - 2);
    localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

    sort_state_t       state_q, state_d;
    logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
    logic [IdxW-1:0]   rd_idx_q, rd_idx_d;
    logic [IdxW-1:0]   j_q, j_d, j_nxt;
    logic [IdxW-1:0]   pass_q, pass_d;
    logic              swapped_q, swapped_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] cmp_a, cmp_b;
    logic              cmp_eq, cmp_a_gt_b, cmp_b_gt_a;
    logic              swap, load_we, swap_we;
    logic              in_ready, out_valid;
    logic [DATA_W-1:0] out_data;

    assign j_nxt = j_q + IdxOne;
    assign cmp_a = mem_q[j_q];
    assign cmp_b = mem_q[j_nxt];

    comparator u_cmp (
        .A      (cmp_a),
        .B      (cmp_b),
        .EQ     (cmp_eq),
        .A_GT_B (cmp_a_gt_b),
        .B_GT_A (cmp_b_gt_a)
    );

    // Only a strict greater-than swaps, which keeps equal values in arrival order.
    assign swap = cmp_a_gt_b & ~cmp_eq & ~cmp_b_gt_a;

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        j_d       = j_q;
        pass_d    = pass_q;
        swapped_d = swapped_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        sorted    = 1'b0;
        busy      = 1'b0;
        load_we   = 1'b0;
        swap_we   = 1'b0;

        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    load_we = 1'b1;
                    if (wr_idx_q == LastIdx) begin
                        state_d   = SORT;
                        j_d       = '0;
                        pass_d    = '0;
                        swapped_d = 1'b0;
                    end else begin
                        wr_idx_d = wr_idx_q + IdxOne;
                    end
                end
            end
            SORT: begin
                busy    = 1'b1;
                swap_we = swap;
                if (j_q == LastJ) begin
                    if (!(swapped_q || swap) || (pass_q == LastJ)) begin
                        state_d = DRAIN;
                        sorted  = 1'b1;
                    end else begin
                        j_d       = '0;
                        pass_d    = pass_q + IdxOne;
                        swapped_d = 1'b0;
                    end
                end else begin
                    j_d       = j_nxt;
                    swapped_d = swapped_q | swap;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = mem_q[rd_idx_q];
                if (bus.out_ready) begin
                    if (rd_idx_q == LastIdx) begin
                        state_d  = LOAD;
                        wr_idx_d = '0;
                        rd_idx_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + IdxOne;
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        // Reset masks every output and buffer write, whatever state was in force.
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            out_data  = '0;
            sorted    = 1'b0;
            busy      = 1'b0;
            load_we   = 1'b0;
            swap_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOAD;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            j_q       <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            j_q       <= j_d;
            pass_q    <= pass_d;
            swapped_q <= swapped_d;
        end
    end

    // Buffer content is don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem_q[wr_idx_q] <= bus.in_data;
        end else if (swap_we) begin
            mem_q[j_q]   <= cmp_b;
            mem_q[j_nxt] <= cmp_a;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;

endmodule

// File: tb/tb_comparator_sort_ctrl.sv
// Scenario bench for comparator_sort_ctrl: loads batches, checks sort latency and drained order.
module tb_comparator_sort_ctrl;
    import comparator_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic sorted;
    logic busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] got_q [$];

    comparator_sort_ctrl_if bus ();

    comparator_sort_ctrl #(
        .DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .sorted (sorted),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] pack4(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c, input logic [3:0] d);
        return {d, c, b, a};
    endfunction

    // Drives one batch (first value in the low nibble); optionally queues its sorted image.
    task automatic load_batch(input logic [15:0] vals, input bit gaps, input bit push,
                              output bit stalled);
        stalled = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 4'hA;
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = vals[4*i +: 4];
            if (bus.in_ready !== 1'b1) stalled = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (push) begin
            for (int v = 0; v < 16; v++) begin
                for (int i = 0; i < 4; i++) begin
                    if (vals[4*i +: 4] == 4'(v)) exp_q.push_back(4'(v));
                end
            end
        end
    endtask

    task automatic wait_sort(output int cycles, output int pulses);
        cycles = 0;
        pulses = 0;
        for (int n = 0; n < 100; n++) begin
            if (bus.out_valid === 1'b1) break;
            if (busy === 1'b1) cycles++;
            if (sorted === 1'b1) pulses++;
            @(negedge clk);
        end
    endtask

    task automatic drain(output int cycles);
        int n_acc;
        n_acc  = 0;
        cycles = 0;
        bus.out_ready = 1'b1;
        while (n_acc < DEPTH && cycles < 100) begin
            if (bus.out_valid === 1'b1) begin
                got_q.push_back(bus.out_data);
                n_acc++;
            end
            cycles++;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
        else n_pass++;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        else n_pass++;
        n_checks++;
        if (sorted !== 1'b0) $display("FAIL reset_sorted got %b want 0", sorted);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else n_pass++;
        n_checks++;
        if (bus.out_data !== 4'd0) $display("FAIL reset_out_data got %0d want 0", bus.out_data);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_reverse();
        bit stalled;
        int cyc, pul, dcyc;
        logic [3:0] e, g;
        load_batch(pack4(4'd3, 4'd1, 4'd2, 4'd0), 1'b0, 1'b1, stalled);
        n_checks++;
        if (stalled) $display("FAIL reverse_load_stall got 1 want 0"); else n_pass++;
        wait_sort(cyc, pul);
        n_checks++;
        if (cyc !== 9) $display("FAIL reverse_sort_cycles got %0d want 9", cyc); else n_pass++;
        n_checks++;
        if (pul !== 1) $display("FAIL reverse_sorted_pulses got %0d want 1", pul); else n_pass++;
        drain(dcyc);
        n_checks++;
        if (dcyc !== 4) $display("FAIL reverse_drain_cycles got %0d want 4", dcyc); else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reverse_reload got %b want 1", bus.in_ready);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 4'hx;
            n_checks++;
            if (g !== e) $display("FAIL reverse_data got %0d want %0d", g, e); else n_pass++;
        end
        got_q.delete();
    endtask

    task automatic test_presorted();
        bit stalled;
        int cyc, pul, dcyc;
        logic [3:0] e, g;
        load_batch(pack4(4'd0, 4'd1, 4'd2, 4'd3), 1'b0, 1'b1, stalled);
        wait_sort(cyc, pul);
        n_checks++;
        if (cyc !== 3) $display("FAIL presorted_sort_cycles got %0d want 3", cyc); else n_pass++;
        n_checks++;
        if (pul !== 1) $display("FAIL presorted_sorted_pulses got %0d want 1", pul); else n_pass++;
        drain(dcyc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 4'hx;
            n_checks++;
            if (g !== e) $display("FAIL presorted_data got %0d want %0d", g, e); else n_pass++;
        end
        got_q.delete();
    endtask

    task automatic test_equal();
        bit stalled;
        int cyc, pul, dcyc;
        logic [3:0] e, g;
        load_batch(pack4(4'd5, 4'd5, 4'd5, 4'd5), 1'b0, 1'b1, stalled);
        wait_sort(cyc, pul);
        n_checks++;
        if (cyc !== 3) $display("FAIL equal_sort_cycles got %0d want 3", cyc); else n_pass++;
        drain(dcyc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 4'hx;
            n_checks++;
            if (g !== e) $display("FAIL equal_data got %0d want %0d", g, e); else n_pass++;
        end
        got_q.delete();
    endtask

    task automatic test_backpressure();
        bit stalled;
        int cyc, pul, dcyc;
        logic [3:0] e, g;
        load_batch(pack4(4'd15, 4'd0, 4'd15, 4'd0), 1'b0, 1'b1, stalled);
        wait_sort(cyc, pul);
        n_checks++;
        if (cyc !== 9) $display("FAIL bp_sort_cycles got %0d want 9", cyc); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[0])
                $display("FAIL bp_hold got valid=%b data=%0d want valid=1 data=%0d",
                         bus.out_valid, bus.out_data, exp_q[0]);
            else n_pass++;
            @(negedge clk);
        end
        drain(dcyc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 4'hx;
            n_checks++;
            if (g !== e) $display("FAIL bp_data got %0d want %0d", g, e); else n_pass++;
        end
        got_q.delete();
    endtask

    task automatic test_mid_sort_reset();
        bit stalled;
        int cyc, pul, dcyc;
        logic [3:0] e, g;
        load_batch(pack4(4'd9, 4'd8, 4'd7, 4'd6), 1'b0, 1'b0, stalled);
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL midrst_in_sort got busy=%b valid=%b want busy=1 valid=0",
                     busy, bus.out_valid);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", bus.in_ready);
        else n_pass++;
        n_checks++;
        if (sorted !== 1'b0) $display("FAIL midrst_sorted got %b want 0", sorted); else n_pass++;
        load_batch(pack4(4'd4, 4'd2, 4'd3, 4'd1), 1'b0, 1'b1, stalled);
        wait_sort(cyc, pul);
        n_checks++;
        if (pul !== 1) $display("FAIL midrst_sorted_pulses got %0d want 1", pul); else n_pass++;
        drain(dcyc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 4'hx;
            n_checks++;
            if (g !== e) $display("FAIL midrst_data got %0d want %0d", g, e); else n_pass++;
        end
        got_q.delete();
    endtask

    task automatic test_ignored_handshakes();
        bit stalled;
        int cyc, pul, dcyc;
        logic [3:0] e, g;
        bus.out_ready = 1'b1;
        load_batch(pack4(4'd7, 4'd3, 4'd9, 4'd1), 1'b1, 1'b1, stalled);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd14;
        wait_sort(cyc, pul);
        drain(dcyc);
        bus.in_valid = 1'b0;
        n_checks++;
        if (dcyc !== 4) $display("FAIL gaps_drain_cycles got %0d want 4", dcyc); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 4'hx;
            n_checks++;
            if (g !== e) $display("FAIL gaps_data got %0d want %0d", g, e); else n_pass++;
        end
        got_q.delete();
    endtask

    initial begin
        test_reset();
        test_reverse();
        test_presorted();
        test_equal();
        test_backpressure();
        test_mid_sort_reset();
        test_ignored_handshakes();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
